// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcodes and instruction format encoding shared by the decode slice
package rv_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: classifies an instruction into its format and builds the 32-bit immediate
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] insn,
  output fmt_e        fmt,
  output logic [31:0] imm,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        rd_used
);
  // every legal opcode ends in 2'b11, so a bad low pair falls through to FMT_X
  always_comb begin
    fmt = FMT_X;
    case (insn[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                            fmt = FMT_S;
      OP_BRANCH:                           fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    fmt = FMT_U;
      OP_JAL:                              fmt = FMT_J;
      OP_REG:                              fmt = FMT_R;
      default:                             fmt = FMT_X;
    endcase
  end
  always_comb begin
    imm = fmt == FMT_I ? {{20{insn[31]}}, insn[31:20]} :
          fmt == FMT_S ? {{20{insn[31]}}, insn[31:25], insn[11:7]} :
          fmt == FMT_B ? {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0} :
          fmt == FMT_U ? {insn[31:12], 12'b0} :
          fmt == FMT_J ? {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0} :
          32'b0;
  end
  assign rs1_used = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign rs2_used = fmt inside {FMT_R, FMT_S, FMT_B};
  assign rd_used  = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode with writeback bypass, load-use stall and the ID/EX register
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1data,
  input  logic [XLEN-1:0] rs2data,
  input  logic            wb_wen,
  input  logic [4:0]      wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_insn,
  output logic [XLEN-1:0] ex_rs1data,
  output logic [XLEN-1:0] ex_rs2data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic            ex_reg_wen,
  output logic            ex_is_load,
  output logic            ex_illegal
);
  fmt_e            fmt;
  logic [31:0]     imm;
  logic            rs1_used, rs2_used, rd_used, adv, luh, take;
  logic [4:0]      rs1, rs2, rd;
  logic            valid_q, valid_d, reg_wen_q, reg_wen_d, is_load_q, is_load_d, illegal_q, illegal_d;
  logic [XLEN-1:0] pc_q, pc_d, op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [31:0]     insn_q, insn_d;
  logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  imm_gen u_imm_gen (
    .insn     (instruction),
    .fmt      (fmt),
    .imm      (imm),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .rd_used  (rd_used)
  );
  // unused register fields are forced to 0 so they can never match a hazard or bypass
  assign rs1  = rs1_used ? instruction[19:15] : 5'd0;
  assign rs2  = rs2_used ? instruction[24:20] : 5'd0;
  assign rd   = rd_used  ? instruction[11:7]  : 5'd0;
  assign adv  = !valid_q || ex_ready;
  assign luh  = valid_q && is_load_q && rd_q != 5'd0 && if_valid &&
                ((rs1_used && rd_q == rs1) || (rs2_used && rd_q == rs2));
  assign take = if_valid && !luh;
  assign if_ready = flush || (adv && !luh);
  always_comb begin
    valid_d   = take;
    pc_d      = take ? if_pc : '0;
    insn_d    = take ? instruction : NOP_INSN;
    op1_d     = !take || rs1 == 5'd0 ? '0 : (wb_wen && wb_waddr == rs1) ? wb_wdata : rs1data;
    op2_d     = !take || rs2 == 5'd0 ? '0 : (wb_wen && wb_waddr == rs2) ? wb_wdata : rs2data;
    imm_d     = take ? XLEN'($signed(imm)) : '0;
    rd_d      = take ? rd : 5'd0;
    rs1_d     = take ? rs1 : 5'd0;
    rs2_d     = take ? rs2 : 5'd0;
    reg_wen_d = take && rd != 5'd0;
    is_load_d = take && instruction[6:0] == OP_LOAD;
    illegal_d = take && fmt == FMT_X;
  end
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      insn_q    <= NOP_INSN;
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= 5'd0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      reg_wen_q <= 1'b0;
      is_load_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (adv) begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      insn_q    <= insn_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      reg_wen_q <= reg_wen_d;
      is_load_q <= is_load_d;
      illegal_q <= illegal_d;
    end
  end
  assign ex_valid   = valid_q;
  assign ex_pc      = pc_q;
  assign ex_insn    = insn_q;
  assign ex_rs1data = op1_q;
  assign ex_rs2data = op2_q;
  assign ex_imm     = imm_q;
  assign ex_rd      = rd_q;
  assign ex_rs1     = rs1_q;
  assign ex_rs2     = rs2_q;
  assign ex_reg_wen = reg_wen_q;
  assign ex_is_load = is_load_q;
  assign ex_illegal = illegal_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with hand-computed expectations for id_ex_stage
module tb_id_ex_stage;
  logic        clk = 1'b0, rst, if_valid, if_ready, wb_wen, flush, ex_ready;
  logic [31:0] if_pc, instruction, rs1data, rs2data, wb_wdata;
  logic [4:0]  wb_waddr;
  logic        ex_valid, ex_reg_wen, ex_is_load, ex_illegal;
  logic [31:0] ex_pc, ex_insn, ex_rs1data, ex_rs2data, ex_imm;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .instruction(instruction), .rs1data(rs1data), .rs2data(rs2data), .wb_wen(wb_wen),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_insn(ex_insn), .ex_rs1data(ex_rs1data),
    .ex_rs2data(ex_rs2data), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_reg_wen(ex_reg_wen), .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0; if_valid = 1'b1; instruction = 32'hFFF00093; if_pc = 32'h100;
    rs1data = 32'h55; rs2data = 32'h66; wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;
    flush = 1'b0; ex_ready = 1'b1;
    step(); step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_insn", ex_insn, 32'h00000013);
    chk("rst_imm", ex_imm, 0);
    rst = 1'b1; if_valid = 1'b0; #1;
    chk("rst_if_ready", if_ready, 1);
    if_valid = 1'b1; step();
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_rd", ex_rd, 1);
    chk("addi_wen", ex_reg_wen, 1);
    chk("addi_x0_op", ex_rs1data, 0);
    chk("addi_pc", ex_pc, 32'h100);
    instruction = 32'h0020A423; rs1data = 32'h11; rs2data = 32'h22; if_pc = 32'h104; step();
    chk("sw_imm", ex_imm, 8);
    chk("sw_wen", ex_reg_wen, 0);
    chk("sw_rd", ex_rd, 0);
    chk("sw_rs1", ex_rs1, 1);
    chk("sw_rs2", ex_rs2, 2);
    chk("sw_op2", ex_rs2data, 32'h22);
    instruction = 32'hFFDFF0EF; step();
    chk("jal_imm", ex_imm, 32'hFFFFFFFC);
    chk("jal_rs1", ex_rs1, 0);
    chk("jal_wen", ex_reg_wen, 1);
    instruction = 32'hFE208CE3; step();
    chk("beq_imm", ex_imm, 32'hFFFFFFF8);
    chk("beq_wen", ex_reg_wen, 0);
    instruction = 32'h123452B7; step();
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_rd", ex_rd, 5);
    instruction = 32'h0000A283; step();
    chk("lw_is_load", ex_is_load, 1);
    instruction = 32'h00728333; #1;
    chk("luh_if_ready", if_ready, 0);
    step();
    chk("luh_bubble_valid", ex_valid, 0);
    chk("luh_bubble_insn", ex_insn, 32'h00000013);
    chk("luh_release", if_ready, 1);
    step();
    chk("luh_add_valid", ex_valid, 1);
    chk("luh_add_insn", ex_insn, 32'h00728333);
    chk("luh_add_rd", ex_rd, 6);
    instruction = 32'h0000A003; step();
    chk("lw_x0_wen", ex_reg_wen, 0);
    instruction = 32'h00700333; #1;
    chk("lw_x0_no_stall", if_ready, 1);
    step();
    chk("lw_x0_next_valid", ex_valid, 1);
    instruction = 32'h00118213; rs1data = 32'h11; wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hABCD; step();
    chk("byp_hit", ex_rs1data, 32'hABCD);
    chk("byp_imm", ex_imm, 1);
    wb_waddr = 5'd0; step();
    chk("byp_x0", ex_rs1data, 32'h11);
    wb_wen = 1'b0; ex_ready = 1'b0; instruction = 32'h0020A423; #1;
    chk("bp_if_ready", if_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_insn", ex_insn, 32'h00118213);
      chk("bp_hold_op1", ex_rs1data, 32'h11);
      chk("bp_hold_valid", ex_valid, 1);
    end
    flush = 1'b1; #1;
    chk("flush_if_ready", if_ready, 1);
    step();
    chk("flush_valid", ex_valid, 0);
    chk("flush_insn", ex_insn, 32'h00000013);
    chk("flush_pc", ex_pc, 0);
    flush = 1'b0; ex_ready = 1'b1; instruction = 32'h0000007F; step();
    chk("ill_valid", ex_valid, 1);
    chk("ill_flag", ex_illegal, 1);
    chk("ill_wen", ex_reg_wen, 0);
    chk("ill_imm", ex_imm, 0);
    instruction = 32'hFFF00090; step();
    chk("ill_lowbits", ex_illegal, 1);
    chk("ill_lowbits_rd", ex_rd, 0);
    rst = 1'b0; step();
    chk("rst2_valid", ex_valid, 0);
    chk("rst2_illegal", ex_illegal, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register for the pipelined RV32I core.
- Sits directly downstream of the register file. It takes the fetched instruction and the register file's combinational rs1/rs2 read data.
- Each cycle it produces a registered decode bundle for EX: operands, immediate, control fields.
- Detects load-use hazards (stalls fetch, inserts a bubble), bypasses same-cycle writeback, and supports flush from branch resolution.

Parameters:
XLEN, 32, datapath width
NOP_INSN, 32'h00000013, instruction word recorded in ex_insn for bubbles

Ports:
clk  in  1  clock
rst  in  1  reset
if_valid  in  1  IF/ID holds a valid instruction
if_ready  out  1  this stage accepts the IF/ID instruction this cycle
if_pc  in  XLEN  PC of incoming instruction
instruction  in  32  incoming instruction; also drives register file read addresses
rs1data  in  XLEN  register file read port 1
rs2data  in  XLEN  register file read port 2
wb_wen  in  1  writeback write enable (same signal as register file write enable)
wb_waddr  in  5  writeback destination
wb_wdata  in  XLEN  writeback data
flush  in  1  kill the instruction in ID and the one in the EX register
ex_ready  in  1  EX consumes the current bundle
ex_valid  out  1  bundle valid
ex_pc  out  XLEN  PC
ex_insn  out  32  raw instruction
ex_rs1data  out  XLEN  operand 1 after bypass
ex_rs2data  out  XLEN  operand 2 after bypass
ex_imm  out  XLEN  sign-extended immediate
ex_rd  out  5  destination register
ex_rs1  out  5  source register 1
ex_rs2  out  5  source register 2
ex_reg_wen  out  1  instruction writes rd (rd≠0 and format R/I/U/J)
ex_is_load  out  1  opcode 0000011
ex_illegal  out  1  unrecognised opcode or instruction[1:0]≠2'b11

Behaviour:
- Reset: rst is synchronous, active-low, on clk. While rst is low at a posedge, all ex_* outputs become 0 except ex_insn, which becomes NOP_INSN.
- Priority at each posedge: rst, then flush, then advance, then hold.
- Advance condition: adv = !ex_valid || ex_ready.
- Load-use hazard:
  - luh = ex_valid && ex_is_load && ex_rd≠0 && if_valid && (ex_rd==rs1 with rs1 used, or ex_rd==rs2 with rs2 used).
  - rs1 is used by all formats except U and J.
  - rs2 is used by R, S and B formats.
- if_ready = adv && !luh, combinational. When flush=1, if_ready=1 so the killed instruction leaves IF/ID.
- Transfer rules at a posedge:
  - adv && if_valid && !luh && !flush: register the decoded bundle, ex_valid=1.
  - adv && (luh || !if_valid) && !flush: insert a bubble (ex_valid=0, fields zero, ex_insn=NOP_INSN).
  - !adv && !flush: all outputs hold, regardless of instruction changes.
  - flush: bubble, even if ex_ready=0.
- Latency: exactly 1 cycle from acceptance to ex_valid.
- A load-use stall lasts exactly 1 bubble cycle once EX accepts the load. The bubble is then in EX, so luh clears.
- Bypass, evaluated combinationally before registering:
  - If wb_wen && wb_waddr≠0 && wb_waddr==rs1, operand 1 = wb_wdata; same rule for rs2.
  - Source index 0 always yields 0, regardless of register file data.
- Immediate by opcode:
  - I (0000011, 0010011, 1100111, 1110011): sign-extended inst[31:20].
  - S (0100011): {inst[31:25], inst[11:7]} sign-extended.
  - B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0} sign-extended.
  - U (0110111, 0010111): {inst[31:12], 12'b0}.
  - J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
  - R (0110011): 0.
- Illegal instruction: passes through with ex_valid=1, ex_illegal=1, ex_reg_wen=0, imm=0. Not a hazard source.
- ex_rd, ex_rs1 and ex_rs2 are zeroed for formats that do not use them.

Decomposition:
- Shared package rv_pkg: opcode localparams (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG, OP_SYSTEM) and the format enum (FMT_R/I/S/B/U/J/X).
- One combinational sub-module imm_gen: instruction → format, imm, rs1_used, rs2_used.
- Pipeline register, hazard and bypass logic stay in id_ex_stage.

Test Plan:
- Reset: hold rst=0 for 2 cycles while if_valid=1 → ex_valid=0, ex_insn=32'h00000013, if_ready=1 after release.
- Immediates: addi x1,x0,-1 (32'hFFF00093) → ex_imm=32'hFFFFFFFF, ex_rd=1. sw x2,8(x1) → ex_imm=8, ex_reg_wen=0. jal x1,-4 (32'hFFDFF0EF) → ex_imm=32'hFFFFFFFC.
- Load-use stall: lw x5,0(x1) accepted, next add x6,x5,x7 → if_ready=0 for 1 cycle, bubble (ex_valid=0), then add issues. With x0 as the load destination → no stall.
- Bypass: rs1=3, register file returns 32'h11, wb_wen=1, wb_waddr=3, wb_wdata=32'hABCD → ex_rs1data=32'hABCD. Same stimulus with wb_waddr=0 → 32'h11.
- Backpressure and flush: ex_ready=0 for 3 cycles → outputs stable, if_ready=0. Assert flush with ex_ready=0 → next cycle ex_valid=0, and the ID instruction is dropped (if_ready=1).
- Illegal: instruction 32'h0000007F → ex_valid=1, ex_illegal=1, ex_reg_wen=0.
